// File: rtl/aes_pkg.sv
// Shared AES types, the forward S-box table, the byte-position helper and the
// FSM state encoding used by the SubBytes engine.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    // Byte 0 sits in [127:120]; returns the LSB position of byte i.
    function automatic int byte_lsb(input int i);
        return 120 - 8 * i;
    endfunction

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: one byte in, its substitution out.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t b,
    output byte_t sb
);

    assign sb = SBOX[b];

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes engine, NSBOX bytes substituted per cycle.
// Optional macro SUB_BYTES_SHIFT_ROWS_EN also applies ShiftRows on the output.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int NSBOX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int NCHUNK = 16 / NSBOX;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);

    generate
        if (!(NSBOX == 1 || NSBOX == 2 || NSBOX == 4 || NSBOX == 8 || NSBOX == 16)) begin : g_bad_nsbox
            $error("sub_bytes_engine: NSBOX must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; out_valid/out_data hold steady until out_ready is seen, and
    // in_ready is only high in IDLE, so accept and output never share a cycle.
    fsm_t          state;
    fsm_t          state_nxt;
    logic [CW-1:0] cnt;
    state_t        st;
    state_t        result;
    int            chunk_base;
    byte_t         lane_in  [NSBOX];
    byte_t         lane_out [NSBOX];

    assign chunk_base = NSBOX * int'(cnt);

    always_comb begin
        for (int k = 0; k < NSBOX; k++) begin
            lane_in[k] = st[byte_lsb(chunk_base + k) +: 8];
        end
    end

    for (genvar k = 0; k < NSBOX; k++) begin : g_sbox
        aes_sbox u_sbox (
            .b  (lane_in[k]),
            .sb (lane_out[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)       state_nxt = BUSY;
            BUSY:    if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    if (out_ready)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Substitution happens in place, one chunk of NSBOX bytes per BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            st  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st  <= in_data;
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < NSBOX; k++) begin
                        st[byte_lsb(chunk_base + k) +: 8] <= lane_out[k];
                    end
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_BYTES_SHIFT_ROWS_EN
    // Output byte 4c+r takes substituted byte 4*((c+r)%4)+r: row r rotates left by r.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign result[byte_lsb(4 * c + r) +: 8] = st[byte_lsb(4 * ((c + r) % 4) + r) +: 8];
        end
    end
`else
    assign result = st;
`endif

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign out_data  = out_valid ? result : '0;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench for sub_bytes_engine with a GF(2^8) reference model and an NSBOX sweep.
module tb_sub_bytes_engine;
    import aes_pkg::*;

    localparam int NSBOX = 4;
    localparam int LAT   = 16 / NSBOX;
    localparam int SW_N [4] = '{1, 2, 8, 16};
`ifdef SUB_BYTES_SHIFT_ROWS_EN
    localparam logic [127:0] APPB_EXP = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
    localparam logic [127:0] APPB_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif
    localparam logic [127:0] APPB_IN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;

    logic [3:0]     sw_in_valid = '0;
    logic [3:0]     sw_in_ready;
    logic [127:0]   sw_in_data = '0;
    logic [3:0]     sw_out_valid;
    logic [3:0]     sw_out_ready = '1;
    logic [4*128-1:0] sw_out_data;

    sub_bytes_engine #(.NSBOX(NSBOX)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    for (genvar j = 0; j < 4; j++) begin : g_sweep
        sub_bytes_engine #(.NSBOX(SW_N[j])) u_sw (
            .clk       (clk),
            .rst       (sw_rst),
            .in_valid  (sw_in_valid[j]),
            .in_ready  (sw_in_ready[j]),
            .in_data   (sw_in_data),
            .out_valid (sw_out_valid[j]),
            .out_ready (sw_out_ready[j]),
            .out_data  (sw_out_data[j*128 +: 128])
        );
    end

    // ---------------- reference model ----------------
    logic [7:0] sbox_m [256];
    logic [7:0] inv_m  [256];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_model();
        logic [7:0] x, inv, s;
        for (int xi = 0; xi < 256; xi++) begin
            x = 8'(xi);
            inv = '0;
            for (int yi = 1; yi < 256; yi++) begin
                if (gf_mul(x, 8'(yi)) == 8'h01) inv = 8'(yi);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_m[xi] = s;
            inv_m[s]   = x;
        end
    endtask

    // Position in the substituted state that ends up in output byte i.
    function automatic int src_pos(input int i);
`ifdef SUB_BYTES_SHIFT_ROWS_EN
        return 4 * (((i / 4) + (i % 4)) % 4) + (i % 4);
`else
        return i;
`endif
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [7:0]   sub [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) sub[i] = sbox_m[s[120 - 8*i +: 8]];
        for (int i = 0; i < 16; i++) o[120 - 8*i +: 8] = sub[src_pos(i)];
        return o;
    endfunction

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [127:0] exp_q [$];
    logic [127:0] in_q  [$];
    int           acc_q [$];
    logic hold = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: samples on the falling edge, pops expected values on each output transfer.
    logic         pv = 1'b0;
    logic         stall = 1'b0;
    logic [127:0] pdata = '0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            pv = 1'b0;
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 128'(out_valid), 128'd1);
                chk("hold_data", out_data, pdata);
            end
            if (out_valid) begin
                chk("in_ready_in_done", 128'(in_ready), 128'd0);
                if (!pv) begin
                    if (acc_q.size() == 0) chk("unexpected_valid", 128'(out_valid), 128'd0);
                    else chk("latency", 128'(cyc - acc_q.pop_front()), 128'(LAT));
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 128'(out_valid), 128'd0);
                    end else begin
                        logic [127:0] src, recon;
                        chk("data", out_data, exp_q.pop_front());
                        src = in_q.pop_front();
                        recon = '0;
                        for (int i = 0; i < 16; i++)
                            recon[120 - 8*src_pos(i) +: 8] = inv_m[out_data[120 - 8*i +: 8]];
                        chk("inverse", recon, src);
                    end
                end
            end
            pv    = out_valid;
            stall = out_valid && !out_ready;
            pdata = out_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [127:0] d, input logic [127:0] e);
        bit acc;
        acc = 1'b0;
        @(posedge clk);
        #1;
        in_data  = d;
        in_valid = 1'b1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) begin
            exp_q.push_back(e);
            in_q.push_back(d);
            acc_q.push_back(cyc);
        end else begin
            chk("accept_timeout", 128'(acc), 128'd1);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 600 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic sweep();
        int           lat [4];
        logic [127:0] got [4];
        int           a;
        for (int j = 0; j < 4; j++) begin
            lat[j] = -1;
            got[j] = '0;
        end
        @(posedge clk);
        #1;
        sw_in_data  = APPB_IN;
        sw_in_valid = '1;
        @(negedge clk);
        chk("sweep_in_ready", 128'(sw_in_ready), 128'hf);
        @(posedge clk);
        #1;
        a = cyc;
        sw_in_valid = '0;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                if (sw_out_valid[j] && lat[j] < 0) begin
                    lat[j] = cyc - a;
                    got[j] = sw_out_data[j*128 +: 128];
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("sweep_latency_n%0d", SW_N[j]), 128'(lat[j]), 128'(16 / SW_N[j]));
            chk($sformatf("sweep_data_n%0d", SW_N[j]), got[j], APPB_EXP);
        end
    endtask

    // ---------------- sequencer ----------------
    initial begin
        logic [127:0] v;
        int tbl_bad;
        build_model();
        tbl_bad = 0;
        for (int i = 0; i < 256; i++) if (sbox_m[i] !== SBOX[i]) tbl_bad++;
        chk("pkg_table_vs_model", 128'(tbl_bad), 128'd0);

        // reset values
        repeat (3) @(posedge clk);
        #2;
        chk("reset_in_ready", 128'(in_ready), 128'd0);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out_data", out_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        sw_rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 128'(in_ready), 128'd1);
        chk("idle_out_valid", 128'(out_valid), 128'd0);

        sweep();

        // single-byte pattern and the FIPS-197 round-1 vector
        send({4{32'h005301ff}}, {4{32'h63ed7c16}});
        send(APPB_IN, APPB_EXP);
        drain();

        // every byte value across 16 back-to-back states
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) v[120 - 8*i +: 8] = 8'(16 * k + i);
            send(v, model(v));
        end
        drain();

        // backpressure: a new in_valid during a stalled output must wait
        @(negedge clk);
        hold = 1'b1;
        v = {$urandom, $urandom, $urandom, $urandom};
        send(v, model(v));
        for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
        chk("bp_valid_seen", 128'(out_valid), 128'd1);
        v = {$urandom, $urandom, $urandom, $urandom};
        fork
            send(v, model(v));
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                chk("bp_no_accept", 128'(in_q.size()), 128'd1);
                chk("bp_in_ready", 128'(in_ready), 128'd0);
                hold = 1'b0;
            end
        join
        drain();

        // asynchronous reset in the middle of BUSY
        send(APPB_IN, APPB_EXP);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_busy_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy_out_data", out_data, 128'd0);
        chk("rst_busy_in_ready", 128'(in_ready), 128'd0);
        exp_q.delete();
        in_q.delete();
        acc_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_release_in_ready", 128'(in_ready), 128'd1);
        send(APPB_IN, APPB_EXP);
        drain();

        // random states with random gaps
        for (int n = 0; n < 24; n++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(v, model(v));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
